// File: rtl/lvds_frame_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | lvds_rx_pkg : shared constants and state encoding for the LVDS frame path   |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

package lvds_rx_pkg;

    localparam int WORD_W    = 32;
    localparam int BIT_CNT_W = $clog2(WORD_W);

    localparam logic [WORD_W-1:0] SYNC_WORD_DEF = 32'h5346444B;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_HUNT   = 2'd1;
    localparam state_t ST_RECV   = 2'd2;
    localparam state_t ST_COMMIT = 2'd3;

endpackage

`default_nettype wire

// File: rtl/lvds_frame_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | lvds_frame_ctrl_if : RAM port-A write bus plus the frame/release toggles    |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

interface lvds_frame_ctrl_if
    import lvds_rx_pkg::*;
#(
    parameter int ADDR_W = 4
);

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              frame_tgl;
    logic              frame_bank;
    logic              bank_rel_tgl;

    modport master (
        output wr_en,
        output wr_addr,
        output wr_data,
        output frame_tgl,
        output frame_bank,
        input  bank_rel_tgl
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  wr_data,
        input  frame_tgl,
        input  frame_bank,
        output bank_rel_tgl
    );

endinterface

`default_nettype wire

// File: rtl/cdc_toggle_sync.sv
// +----------------------------------------------------------------------------+
// | cdc_toggle_sync : 2-FF toggle synchroniser with XOR edge detect -> pulse    |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module cdc_toggle_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic tgl_in,
    output logic pulse_out
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], tgl_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Pulse is a function of flops only, so it is glitch-free in the destination domain
    assign pulse_out = sync_q[2] ^ sync_q[1];

endmodule

`default_nettype wire

// File: rtl/lvds_frame_ctrl.sv
// +----------------------------------------------------------------------------+
// | lvds_frame_ctrl : sync hunt, payload capture into ping-pong banks, handoff  |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module lvds_frame_ctrl
    import lvds_rx_pkg::*;
#(
    parameter logic [31:0] SYNC_WORD = SYNC_WORD_DEF,
    parameter int          WORDS     = 8,
    parameter int          CNT_W     = 8
) (
    input  logic             lvds_clk,
    input  logic             rst_n,
    input  logic             lvds_data_in,
    input  logic             cap_en,
    lvds_frame_ctrl_if.master bus,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic [CNT_W-1:0] abort_cnt,
    output logic             busy
);

    localparam int WA_W   = $clog2(WORDS);
    localparam int ADDR_W = WA_W + 1;

    logic [WORD_W-2:0]    sr_q;
    logic [WORD_W-1:0]    sr_d;
    state_t               state_q,      state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q,    bit_cnt_d;
    logic [WA_W-1:0]      word_cnt_q,   word_cnt_d;
    logic                 wr_bank_q,    wr_bank_d;
    logic                 rd_bank_q,    rd_bank_d;
    logic [1:0]           full_q,       full_d;
    logic                 wr_en_q,      wr_en_d;
    logic [ADDR_W-1:0]    wr_addr_q,    wr_addr_d;
    logic [WORD_W-1:0]    wr_data_q,    wr_data_d;
    logic                 frame_tgl_q,  frame_tgl_d;
    logic                 frame_bank_q, frame_bank_d;
    logic [CNT_W-1:0]     ovf_cnt_q,    ovf_cnt_d;
    logic [CNT_W-1:0]     abort_cnt_q,  abort_cnt_d;
    logic                 rel_pulse;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    cdc_toggle_sync u_rel_sync (
        .clk       (lvds_clk),
        .rst_n     (rst_n),
        .tgl_in    (bus.bank_rel_tgl),
        .pulse_out (rel_pulse)
    );

    always_comb begin
        // sr_d is the 32-bit window including the bit sampled on this edge, so the
        // sync is seen on the edge of its last bit and payload words align exactly.
        sr_d         = {sr_q, lvds_data_in};
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        word_cnt_d   = word_cnt_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        full_d       = full_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        frame_tgl_d  = frame_tgl_q;
        frame_bank_d = frame_bank_q;
        ovf_cnt_d    = ovf_cnt_q;
        abort_cnt_d  = abort_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (cap_en) begin
                    state_d = ST_HUNT;
                end
            end
            ST_HUNT: begin
                if (!cap_en) begin
                    state_d = ST_IDLE;
                end else if (sr_d == SYNC_WORD) begin
                    if (!full_q[wr_bank_q]) begin
                        state_d    = ST_RECV;
                        bit_cnt_d  = '0;
                        word_cnt_d = '0;
                    end else begin
                        ovf_cnt_d = sat_inc(ovf_cnt_q);
                    end
                end
            end
            ST_RECV: begin
                if (!cap_en) begin
                    state_d     = ST_IDLE;
                    abort_cnt_d = sat_inc(abort_cnt_q);
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_CNT_W'(WORD_W - 1)) begin
                        wr_en_d    = 1'b1;
                        wr_data_d  = sr_d;
                        wr_addr_d  = {wr_bank_q, word_cnt_q};
                        word_cnt_d = word_cnt_q + 1'b1;
                        if (word_cnt_q == WA_W'(WORDS - 1)) begin
                            state_d = ST_COMMIT;
                        end
                    end
                end
            end
            ST_COMMIT: begin
                frame_bank_d = wr_bank_q;
                frame_tgl_d  = ~frame_tgl_q;
                wr_bank_d    = ~wr_bank_q;
                state_d      = cap_en ? ST_HUNT : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Release is applied first so a commit to the same bank bit overrides it
        if (rel_pulse && full_q[rd_bank_q]) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
        if (state_q == ST_COMMIT) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    always_ff @(posedge lvds_clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q         <= '0;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            full_q       <= 2'b00;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            frame_tgl_q  <= 1'b0;
            frame_bank_q <= 1'b0;
            ovf_cnt_q    <= '0;
            abort_cnt_q  <= '0;
        end else begin
            sr_q         <= sr_d[WORD_W-2:0];
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            word_cnt_q   <= word_cnt_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            full_q       <= full_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            frame_tgl_q  <= frame_tgl_d;
            frame_bank_q <= frame_bank_d;
            ovf_cnt_q    <= ovf_cnt_d;
            abort_cnt_q  <= abort_cnt_d;
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.frame_tgl  = frame_tgl_q;
    assign bus.frame_bank = frame_bank_q;
    assign ovf_cnt        = ovf_cnt_q;
    assign abort_cnt      = abort_cnt_q;
    assign busy           = (state_q != ST_IDLE);

endmodule

`default_nettype wire
